// File: rtl/pc_sequencer.sv
// Next-PC selection and fetch sequencing controller for the five-stage RISC-V PC register.
// Optional trap redirect is compiled in when the macro PC_SEQ_TRAP_EN is defined.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] pc_current,
    output logic [31:0] pc_next,
    output logic        pc_enable,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        fetch_valid,
    input  logic        load_use_hazard,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
`ifdef PC_SEQ_TRAP_EN
    input  logic        trap_req,
`endif
    input  logic        halt_req,
    input  logic        resume,
    output logic        flush_ifid,
    output logic        flush_idex
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    // Redirect priority classes; a larger value wins.
    localparam logic [1:0] PRI_NONE   = 2'd0;
    localparam logic [1:0] PRI_JUMP   = 2'd1;
    localparam logic [1:0] PRI_BRANCH = 2'd2;
    localparam logic [1:0] PRI_TRAP   = 2'd3;

    state_t      state_r;
    state_t      state_nx_s;
    logic        pend_valid_r;
    logic        pend_valid_nx_s;
    logic [1:0]  pend_pri_r;
    logic [1:0]  pend_pri_nx_s;
    logic [31:0] pend_tgt_r;
    logic [31:0] pend_tgt_nx_s;

    logic        trap_s;
    logic [1:0]  new_pri_s;
    logic [31:0] new_tgt_s;
    logic        new_wins_s;
    logic        redirect_s;
    logic [31:0] sel_tgt_s;
    logic        capture_s;
    logic        clear_pend_s;

    logic [31:0] pc_next_s;
    logic        pc_enable_s;
    logic        imem_req_s;
    logic        fetch_valid_s;

`ifdef PC_SEQ_TRAP_EN
    assign trap_s = trap_req;
`else
    assign trap_s = 1'b0;
`endif

    // Resolve the highest-priority redirect presented this cycle.
    always_comb begin
        if (trap_s) begin
            new_pri_s = PRI_TRAP;
            new_tgt_s = TRAP_VECTOR;
        end else if (branch_taken) begin
            new_pri_s = PRI_BRANCH;
            new_tgt_s = branch_target;
        end else if (jump_valid) begin
            new_pri_s = PRI_JUMP;
            new_tgt_s = jump_target;
        end else begin
            new_pri_s = PRI_NONE;
            new_tgt_s = 32'h0000_0000;
        end
    end

    // A new redirect beats the pending one only with strictly higher priority.
    assign new_wins_s = (new_pri_s != PRI_NONE) &&
                        (!pend_valid_r || (new_pri_s > pend_pri_r));
    assign redirect_s = (new_pri_s != PRI_NONE) || pend_valid_r;
    assign sel_tgt_s  = new_wins_s ? new_tgt_s : pend_tgt_r;

    // Next-state and raw fetch outputs.
    always_comb begin
        state_nx_s    = state_r;
        pc_next_s     = pc_current;
        pc_enable_s   = 1'b0;
        imem_req_s    = 1'b0;
        fetch_valid_s = 1'b0;
        capture_s     = 1'b0;
        clear_pend_s  = 1'b0;
        case (state_r)
            ST_BOOT: begin
                pc_enable_s = 1'b1;
                pc_next_s   = RESET_VECTOR;
                capture_s   = 1'b1;
                state_nx_s  = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (!imem_ready) begin
                    capture_s = 1'b1;
                end else if (redirect_s) begin
                    // The instruction returned this cycle is on the wrong path.
                    pc_enable_s  = 1'b1;
                    pc_next_s    = sel_tgt_s;
                    clear_pend_s = 1'b1;
                end else if (load_use_hazard) begin
                    pc_enable_s = 1'b0;
                end else begin
                    pc_enable_s   = 1'b1;
                    pc_next_s     = pc_current + 32'd4;
                    fetch_valid_s = 1'b1;
                    if (halt_req) begin
                        state_nx_s = ST_HALT;
                    end else begin
                        state_nx_s = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                capture_s = 1'b1;
                if (resume || trap_s) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_HALT;
                end
            end
            default: begin
                state_nx_s   = ST_BOOT;
                clear_pend_s = 1'b1;
            end
        endcase
    end

    // Next value of the single-entry pending-redirect register.
    always_comb begin
        pend_valid_nx_s = pend_valid_r;
        pend_pri_nx_s   = pend_pri_r;
        pend_tgt_nx_s   = pend_tgt_r;
        if (clear_pend_s) begin
            pend_valid_nx_s = 1'b0;
            pend_pri_nx_s   = PRI_NONE;
        end else if (capture_s && new_wins_s) begin
            pend_valid_nx_s = 1'b1;
            pend_pri_nx_s   = new_pri_s;
            pend_tgt_nx_s   = new_tgt_s;
        end else begin
            pend_valid_nx_s = pend_valid_r;
            pend_pri_nx_s   = pend_pri_r;
            pend_tgt_nx_s   = pend_tgt_r;
        end
    end

    // State and pending registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_BOOT;
            pend_valid_r <= 1'b0;
            pend_pri_r   <= PRI_NONE;
            pend_tgt_r   <= 32'h0000_0000;
        end else begin
            state_r      <= state_nx_s;
            pend_valid_r <= pend_valid_nx_s;
            pend_pri_r   <= pend_pri_nx_s;
            pend_tgt_r   <= pend_tgt_nx_s;
        end
    end

    // While reset is held every output is quiet so the PC cannot load mid-reset.
    always_comb begin
        if (!reset_n) begin
            pc_next     = RESET_VECTOR;
            pc_enable   = 1'b0;
            imem_req    = 1'b0;
            fetch_valid = 1'b0;
            flush_ifid  = 1'b0;
            flush_idex  = 1'b0;
        end else begin
            pc_next     = pc_next_s;
            pc_enable   = pc_enable_s;
            imem_req    = imem_req_s;
            fetch_valid = fetch_valid_s;
            flush_ifid  = jump_valid | branch_taken | trap_s;
            flush_idex  = branch_taken | trap_s;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner sequences
// and a randomized run against a behavioural next-PC model.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
`ifdef PC_SEQ_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] pc_current;
    logic [31:0] pc_next;
    logic        pc_enable;
    logic        imem_req;
    logic        imem_ready;
    logic        fetch_valid;
    logic        load_use_hazard;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
`ifdef PC_SEQ_TRAP_EN
    logic        trap_req;
`endif
    logic        halt_req;
    logic        resume;
    logic        flush_ifid;
    logic        flush_idex;

    logic        pc_load;
    logic [31:0] pc_load_val;

    typedef struct {
        logic        ready;
        logic        hazard;
        logic        jv;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        trap;
        logic        halt;
        logic        resume;
    } in_t;

    typedef struct {
        logic [31:0] pc;
        in_t         stim;
        logic        en;
        logic [31:0] nxt;
        logic        fv;
        logic        fi;
        logic        fe;
    } vec_t;

    typedef struct {
        int          prio;
        logic [31:0] tgt;
    } redir_t;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_mode;
    redir_t      m_pend[$];
    logic [31:0] m_pc;

    vec_t        tbl[10];
    in_t         v;
    logic        e_en, e_req, e_fv, e_fi, e_fe;
    logic [31:0] e_nxt;

    pc_sequencer #(
        .RESET_VECTOR(RESET_VEC),
        .TRAP_VECTOR (TRAP_VEC)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pc_current     (pc_current),
        .pc_next        (pc_next),
        .pc_enable      (pc_enable),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .fetch_valid    (fetch_valid),
        .load_use_hazard(load_use_hazard),
        .jump_valid     (jump_valid),
        .jump_target    (jump_target),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
`ifdef PC_SEQ_TRAP_EN
        .trap_req       (trap_req),
`endif
        .halt_req       (halt_req),
        .resume         (resume),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex)
    );

    always #5 clock = ~clock;

    // The PC register the sequencer drives, with a bench-side preload.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_current <= 32'hDEAD_BEEF;
        end else if (pc_load) begin
            pc_current <= pc_load_val;
        end else if (pc_enable) begin
            pc_current <= pc_next;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic en, input logic [31:0] nxt,
                              input logic req, input logic fv, input logic fi, input logic fe);
        chk({tag, ".pc_enable"}, 32'(pc_enable), 32'(en));
        if (en) chk({tag, ".pc_next"}, pc_next, nxt);
        chk({tag, ".imem_req"}, 32'(imem_req), 32'(req));
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
        chk({tag, ".flush_ifid"}, 32'(flush_ifid), 32'(fi));
        chk({tag, ".flush_idex"}, 32'(flush_idex), 32'(fe));
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, ".pc_next"}, pc_next, RESET_VEC);
        chk({tag, ".pc_enable"}, 32'(pc_enable), 32'd0);
        chk({tag, ".imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'd0);
        chk({tag, ".flush_ifid"}, 32'(flush_ifid), 32'd0);
        chk({tag, ".flush_idex"}, 32'(flush_idex), 32'd0);
    endtask

    function automatic in_t mkin(input logic r, input logic h, input logic jv, input logic [31:0] jt,
                                 input logic br, input logic [31:0] bt, input logic tr,
                                 input logic hl, input logic rs);
        in_t x;
        x.ready = r; x.hazard = h; x.jv = jv; x.jt = jt; x.br = br; x.bt = bt;
        x.trap = tr; x.halt = hl; x.resume = rs;
        return x;
    endfunction

    function automatic in_t rdy(input logic r);
        return mkin(r, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t mkv(input logic [31:0] pc, input in_t s, input logic en,
                                 input logic [31:0] nxt, input logic fv, input logic fi, input logic fe);
        vec_t x;
        x.pc = pc; x.stim = s; x.en = en; x.nxt = nxt; x.fv = fv; x.fi = fi; x.fe = fe;
        return x;
    endfunction

    task automatic drive(input in_t s);
        imem_ready      = s.ready;
        load_use_hazard = s.hazard;
        jump_valid      = s.jv;
        jump_target     = s.jt;
        branch_taken    = s.br;
        branch_target   = s.bt;
`ifdef PC_SEQ_TRAP_EN
        trap_req        = s.trap;
`endif
        halt_req        = s.halt;
        resume          = s.resume;
    endtask

    task automatic apply(input in_t s);
        @(negedge clock);
        pc_load = 1'b0;
        drive(s);
        #1;
    endtask

    task automatic load_pc(input logic [31:0] val);
        @(negedge clock);
        drive(rdy(1'b0));
        pc_load     = 1'b1;
        pc_load_val = val;
    endtask

    // Reference: fetch/halt behaviour from the priority and pending rules.
    task automatic model_step(input in_t s, output logic en, output logic [31:0] nxt,
                              output logic req, output logic fv, output logic fi, output logic fe);
        int np;
        int pp;
        logic [31:0] nt;
        logic tr;
        redir_t r;
        tr = TRAP_ON ? s.trap : 1'b0;
        np = tr ? 3 : (s.br ? 2 : (s.jv ? 1 : 0));
        nt = tr ? TRAP_VEC : (s.br ? s.bt : s.jt);
        pp = (m_pend.size() != 0) ? m_pend[0].prio : 0;
        r.prio = np;
        r.tgt  = nt;
        fi = (np != 0);
        fe = (np >= 2);
        en = 1'b0; nxt = m_pc; req = 1'b0; fv = 1'b0;
        if (m_mode == 1) begin
            req = 1'b1;
            if (!s.ready) begin
                if (np > pp) begin m_pend.delete(); m_pend.push_back(r); end
            end else if (np != 0 || pp != 0) begin
                en  = 1'b1;
                nxt = (np > pp) ? nt : m_pend[0].tgt;
                m_pend.delete();
            end else if (!s.hazard) begin
                en  = 1'b1;
                nxt = m_pc + 32'd4;
                fv  = 1'b1;
                if (s.halt) m_mode = 2;
            end
        end else begin
            if (np > pp) begin m_pend.delete(); m_pend.push_back(r); end
            if (s.resume || tr) m_mode = 1;
        end
        if (en) m_pc = nxt;
    endtask

    initial begin
        pc_load = 1'b0;
        pc_load_val = 32'h0;
        reset_n = 1'b0;
        drive(rdy(1'b1));
        jump_valid  = 1'b1;
        jump_target = 32'h80;

        tbl[0] = mkv(32'h100, rdy(1'b1), 1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
        tbl[1] = mkv(32'h100, rdy(1'b0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tbl[2] = mkv(32'h200, mkin(1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0), 1'b1, 32'h400, 1'b0, 1'b1, 1'b0);
        tbl[3] = mkv(32'h200, mkin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0), 1'b1, 32'h600, 1'b0, 1'b1, 1'b1);
        tbl[4] = mkv(32'h200, mkin(1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0), 1'b1, 32'h600, 1'b0, 1'b1, 1'b1);
        tbl[5] = mkv(32'h300, mkin(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tbl[6] = mkv(32'h300, mkin(1'b1, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0), 1'b1, 32'h700, 1'b0, 1'b1, 1'b0);
        tbl[7] = mkv(32'hFFFF_FFFC, rdy(1'b1), 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        tbl[8] = mkv(32'h7FFF_FFFC, rdy(1'b1), 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        tbl[9] = mkv(32'h300, mkin(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0), 1'b1, 32'h44, 1'b0, 1'b1, 1'b1);

        // Reset and boot.
        repeat (2) @(negedge clock);
        #1;
        expect_reset("reset");
        @(negedge clock);
        reset_n = 1'b1;
        drive(rdy(1'b1));
        #1;
        expect_out("boot", 1'b1, RESET_VEC, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(rdy(1'b1));
            chk("boot.pc", pc_current, 32'(4 * i));
            expect_out("seq", 1'b1, 32'(4 * i + 4), 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Wait states.
        load_pc(32'h10);
        for (int i = 0; i < 3; i++) begin
            apply(rdy(1'b0));
            chk("wait.pc", pc_current, 32'h10);
            expect_out("wait", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        apply(rdy(1'b1));
        expect_out("wait_rdy", 1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 1'b0);
        apply(rdy(1'b0));
        chk("wait_rdy.pc", pc_current, 32'h14);

        // Redirects arriving during a wait.
        load_pc(32'h20);
        apply(mkin(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        expect_out("rdw_j", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply(mkin(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0));
        expect_out("rdw_b", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        apply(rdy(1'b1));
        expect_out("rdw_apply", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(rdy(1'b0));
        chk("rdw.pc", pc_current, 32'h40);
        apply(mkin(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0));
        apply(mkin(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        apply(mkin(1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        expect_out("pend_keep", 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef PC_SEQ_TRAP_EN
        apply(mkin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0));
        expect_out("trap_br", 1'b1, TRAP_VEC, 1'b1, 1'b0, 1'b1, 1'b1);
`endif

        // Load-use stall.
        load_pc(32'h30);
        apply(mkin(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        expect_out("lu_stall", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(rdy(1'b1));
        chk("lu.pc", pc_current, 32'h30);
        expect_out("lu_go", 1'b1, 32'h34, 1'b1, 1'b1, 1'b0, 1'b0);

        // Halt at the top of memory, wrap, resume, reset mid-halt.
        load_pc(32'hFFFF_FFFC);
        apply(mkin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
        expect_out("halt_wrap", 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        apply(rdy(1'b1));
        chk("halt.pc", pc_current, 32'h0);
        expect_out("halted", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(mkin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
        expect_out("resume", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(rdy(1'b1));
        expect_out("resumed", 1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        apply(mkin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
        apply(mkin(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        expect_out("halt_j", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_reset("reset_halt");
        @(negedge clock);
        reset_n = 1'b1;
        drive(rdy(1'b1));
        #1;
        expect_out("reboot", 1'b1, RESET_VEC, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(rdy(1'b1));
        chk("reboot.pc", pc_current, RESET_VEC);
        expect_out("reboot_seq", 1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef PC_SEQ_TRAP_EN
        apply(mkin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
        apply(mkin(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0));
        expect_out("halt_trap", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        apply(rdy(1'b1));
        expect_out("halt_trap_go", 1'b1, TRAP_VEC, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Vector table, each from a freshly loaded PC with nothing pending.
        for (int k = 0; k < 10; k++) begin
            load_pc(tbl[k].pc);
            apply(tbl[k].stim);
            expect_out($sformatf("vec%0d", k), tbl[k].en, tbl[k].nxt, 1'b1,
                       tbl[k].fv, tbl[k].fi, tbl[k].fe);
        end

        // Randomized run against the reference model.
        load_pc(32'h1000);
        m_mode = 1;
        m_pend.delete();
        m_pc = 32'h1000;
        for (int c = 0; c < 1500; c++) begin
            v.ready  = ($urandom_range(0, 9) < 7);
            v.hazard = ($urandom_range(0, 9) < 2);
            v.jv     = ($urandom_range(0, 9) < 2);
            v.jt     = $urandom() & 32'hFFFF_FFFC;
            v.br     = ($urandom_range(0, 9) < 1);
            v.bt     = $urandom() & 32'hFFFF_FFFC;
            v.trap   = TRAP_ON && ($urandom_range(0, 19) == 0);
            v.halt   = ($urandom_range(0, 19) == 0);
            v.resume = ($urandom_range(0, 3) == 0);
            apply(v);
            chk("rnd.pc", pc_current, m_pc);
            model_step(v, e_en, e_nxt, e_req, e_fv, e_fi, e_fe);
            expect_out("rnd", e_en, e_nxt, e_req, e_fv, e_fi, e_fe);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC selection and fetch sequencing controller for the PC register of the five-stage RISC-V pipeline. Each cycle it picks the value for the PC's `port_in` and drives the PC `enable` input. It arbitrates among sequential fetch, jump redirects from ID, branch redirects from EX and an optional trap. It also runs the instruction-memory fetch handshake and generates the IF/ID and ID/EX flush strobes.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.
- `TRAP_VECTOR`, default 32'h0000_0100: redirect target for traps; only used when `PC_SEQ_TRAP_EN` is defined.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pc_current` in 32: PC register `port_out`.
- `pc_next` out 32: to PC `port_in`.
- `pc_enable` out 1: to PC `enable`.
- `imem_req` out 1: fetch request; the address is `pc_current`.
- `imem_ready` in 1: instruction data valid this cycle.
- `fetch_valid` out 1: the fetched instruction is to be written into IF/ID.
- `load_use_hazard` in 1: decode stall request.
- `jump_valid` in 1, `jump_target` in 32: JAL/JALR redirect from ID.
- `branch_taken` in 1, `branch_target` in 32: taken branch from EX.
- `trap_req` in 1: trap request; port exists only with `PC_SEQ_TRAP_EN`.
- `halt_req` in 1, `resume` in 1: halt control.
- `flush_ifid` out 1, `flush_idex` out 1: pipeline flush strobes.

## Operation
- States: BOOT, FETCH, HALT.
- **Reset values:** while `reset_n`=0 and in BOOT, `pc_next`=RESET_VECTOR. All other outputs are 0. The pending-redirect register is cleared.
- **BOOT:**
  - `pc_enable`=1, `pc_next`=RESET_VECTOR, `imem_req`=0.
  - Always moves to FETCH on the next edge.
- **Redirect priority:** trap > branch > jump. A redirect source is "new" when its valid input is high this cycle.
- **Pending register:** one entry, holding valid and a 32-bit target.
  - A new redirect is captured if pending is empty.
  - A higher-priority new redirect overwrites a lower-priority pending one.
  - An equal- or lower-priority new redirect is ignored while pending is valid.
- **Flush strobes:** combinational in the cycle a redirect input is seen, whether it is captured or applied.
  - Branch or trap: `flush_ifid`=1 and `flush_idex`=1.
  - Jump: `flush_ifid`=1 only.
- **FETCH:** `imem_req`=1.
  - `imem_ready`=0: `pc_enable`=0, `fetch_valid`=0; new redirects go to pending.
  - `imem_ready`=1 with a new redirect or valid pending: `pc_enable`=1, `pc_next` = the winning target between new and pending, `fetch_valid`=0 (wrong-path fetch discarded). Pending is cleared.
  - `imem_ready`=1 with `load_use_hazard`=1 and no redirect: `pc_enable`=0, `fetch_valid`=0. The same PC is refetched.
  - `imem_ready`=1 otherwise: `pc_enable`=1, `pc_next`=`pc_current`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), `fetch_valid`=1.
  - If `halt_req`=1 in that same sequential-advance cycle, the next state is HALT.
- **HALT:**
  - `imem_req`=0, `pc_enable`=0.
  - Redirects are still captured into pending.
  - `resume`=1 moves to FETCH. Pending is applied at the next accepted fetch.
  - `halt_req` is ignored in HALT and in BOOT.

## Timing
- Sequential fetch latency: `imem_ready` high in cycle N gives `pc_current`=old+4 in N+1.
- Redirect applied in cycle N gives `pc_current`=target in N+1, with `imem_req` still asserted.
- Redirect arriving during a wait is held until the cycle `imem_ready`=1, then applied.
- No redirect is ever lost.
- All outputs are combinational from state, pending and inputs. State and pending are registered.
- Reset asserted mid-wait or mid-halt: outputs drop immediately (asynchronous). The first edge after deassertion is a BOOT cycle.

## Configuration
- `PC_SEQ_TRAP_EN` defined:
  - `trap_req` port exists with the highest priority.
  - Target is TRAP_VECTOR.
  - In HALT, a trap also forces the move to FETCH.
- `PC_SEQ_TRAP_EN` undefined:
  - No `trap_req` port.
  - Priority is branch > jump.
  - TRAP_VECTOR is unused.

## Test plan
- **Reset/boot:** release `reset_n` with `imem_ready`=1 held → cycle 1 `pc_enable`=1, `pc_next`=0; then PC steps 0, 4, 8, each with `fetch_valid`=1.
- **Wait state:** `imem_ready` low for 3 cycles at PC 0x10 → `pc_enable`=0 and `fetch_valid`=0 throughout. On the first ready, PC goes to 0x14.
- **Redirect during wait:** at PC 0x20 with `imem_ready`=0, `jump_valid`=1 to 0x80, then `branch_taken`=1 to 0x40 the next cycle → flushes pulse each cycle. On ready, PC=0x40 and `fetch_valid`=0.
- **Simultaneous redirect with trap compiled in:** `branch_taken` and `trap_req` both 1 with ready → PC=0x100, both flushes high.
- **Load-use stall:** `load_use_hazard`=1 with ready at PC 0x30 → PC stays 0x30, `fetch_valid`=0. Next cycle with ready, PC goes to 0x34.
- **Halt and wrap:**
  - `halt_req` at PC 0xFFFF_FFFC → PC goes to 0, then `imem_req`=0 while halted.
  - `resume` → fetch resumes at 0.
  - Assert `reset_n`=0 mid-halt → all outputs 0 immediately.
